// File: rtl/dds_multi.sv
// dds_multi: N-channel DDS with shadowed config, atomic commit and ROM-based sine
module dds_multi #(
  parameter int N_CH = 2,
  parameter int ACC_W = 32,
  parameter int LUT_AW = 10,
  parameter int DAC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_ch,
  input  logic [1:0]              cfg_addr,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_commit,
  input  logic                    cfg_phase_rst,
  output logic [N_CH*LUT_AW-1:0]  lut_addr,
  input  logic [N_CH*DAC_W-1:0]   lut_data,
  output logic [N_CH*DAC_W-1:0]   da,
  output logic                    da_valid,
  output logic                    sync_out
);
  localparam logic [DAC_W-1:0] MID = DAC_W'(1) << (DAC_W-1);
  logic wr, cm, prst, carry0;
  logic [3:0] vld_sr;
  assign wr = cfg_valid && cfg_ready;
  assign cm = cfg_commit && cfg_ready;
  assign prst = cm && cfg_phase_rst;
  assign da_valid = vld_sr[3];
  always_ff @(posedge clk)
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      vld_sr <= '0;
      sync_out <= 1'b0;
    end else begin
      cfg_ready <= !cm;
      vld_sr <= {vld_sr[2:0], 1'b1};
      sync_out <= carry0 && !prst;
    end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    logic [ACC_W-1:0] sh_freq, freq, n_freq, acc, nacc;
    logic [LUT_AW-1:0] sh_phase, phase, n_phase, p, p_d;
    logic [LUT_AW-2:0] t;
    logic [8:0] sh_amp, amp, n_amp, wr_amp;
    logic [2:0] sh_mode, mode, n_mode;
    logic [DAC_W-1:0] rom, saw, trg, w, w_r, da_r;
    logic signed [DAC_W+9:0] prod;
    assign hit = wr && cfg_ch == 8'(g);
    assign wr_amp = cfg_data[8:0] > 9'd256 ? 9'd256 : cfg_data[8:0];
    assign n_freq = hit && cfg_addr == 2'd0 ? cfg_data[ACC_W-1:0] : sh_freq;
    assign n_phase = hit && cfg_addr == 2'd1 ? cfg_data[LUT_AW-1:0] : sh_phase;
    assign n_amp = hit && cfg_addr == 2'd2 ? wr_amp : sh_amp;
    assign n_mode = hit && cfg_addr == 2'd3 ? cfg_data[2:0] : sh_mode;
    assign nacc = acc + freq;
    assign rom = lut_data[g*DAC_W +: DAC_W];
    assign t = p_d[LUT_AW-1] ? ~p_d[LUT_AW-2:0] : p_d[LUT_AW-2:0];
    assign saw = (DAC_W'(p_d) << (DAC_W-LUT_AW)) ^ MID;
    assign trg = (DAC_W'(t) << (DAC_W-LUT_AW+1)) ^ MID;
    always_comb
      w = mode == 3'd0 ? rom ^ MID :
          mode == 3'd1 ? (p_d[LUT_AW-1] ? MID : ~MID) :
          mode == 3'd2 ? saw :
          mode == 3'd3 ? trg :
          mode == 3'd4 ? ~MID : '0;
    assign prod = (DAC_W+10)'($signed(w_r)) * (DAC_W+10)'($signed({1'b0, amp}));
    always_ff @(posedge clk)
      if (!rst_n) begin
        sh_freq <= '0;
        sh_phase <= '0;
        sh_amp <= '0;
        sh_mode <= '0;
        freq <= '0;
        phase <= '0;
        amp <= '0;
        mode <= '0;
        acc <= '0;
        p <= '0;
        p_d <= '0;
        w_r <= '0;
        da_r <= MID;
      end else begin
        sh_freq <= n_freq;
        sh_phase <= n_phase;
        sh_amp <= n_amp;
        sh_mode <= n_mode;
        if (cm) begin
          freq <= n_freq;
          phase <= n_phase;
          amp <= n_amp;
          mode <= n_mode;
        end
        acc <= prst ? '0 : nacc;
        p <= acc[ACC_W-1 -: LUT_AW] + phase;
        p_d <= p;
        w_r <= w;
        da_r <= DAC_W'(prod >>> 8) ^ MID;
      end
    assign lut_addr[g*LUT_AW +: LUT_AW] = p;
    assign da[g*DAC_W +: DAC_W] = da_r;
  end
  // a wrapped sum is smaller than the value it started from
  assign carry0 = g_ch[0].nacc < g_ch[0].acc;
endmodule
